// File: rtl/halut_decoder_ctrl.sv
// HALUT decoder-array controller: LUT load, encoded-index sequencing with result credit, result FIFO.
// Optional performance counters are built only when HALUT_CTRL_PERF_EN is defined.
package halut_pkg;
   localparam int DecoderUnits  = 4;
   localparam int C             = 3;
   localparam int K             = 16;
   localparam int DataTypeWidth = 8;
endpackage

module halut_decoder_ctrl #(
   parameter int DecoderUnits  = halut_pkg::DecoderUnits,
   parameter int C             = halut_pkg::C,
   parameter int K             = halut_pkg::K,
   parameter int DataTypeWidth = halut_pkg::DataTypeWidth,
   parameter int FifoDepth     = 2 * DecoderUnits,
   parameter int DA            = $clog2(DecoderUnits),
   parameter int CA            = $clog2(C),
   parameter int TD            = $clog2(K),
   parameter int TA            = $clog2(C * K)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [15:0]              num_rows_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   input  logic                     lut_valid_i,
   output logic                     lut_ready_o,
   input  logic [DA-1:0]            lut_m_i,
   input  logic [TA-1:0]            lut_addr_i,
   input  logic [DataTypeWidth-1:0] lut_data_i,
   input  logic                     enc_valid_i,
   output logic                     enc_ready_o,
   input  logic [TD-1:0]            enc_k_i,
   output logic [DA-1:0]            dec_m_addr_o,
   output logic [TA-1:0]            dec_waddr_o,
   output logic [DataTypeWidth-1:0] dec_wdata_o,
   output logic                     dec_we_o,
   output logic [CA-1:0]            dec_c_addr_o,
   output logic [TD-1:0]            dec_k_addr_o,
   output logic                     dec_decoder_o,
   input  logic [31:0]              dec_result_i,
   input  logic                     dec_valid_i,
   input  logic [DA-1:0]            dec_m_addr_i,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic [31:0]              res_data_o,
   output logic [DA-1:0]            res_m_o,
   output logic [31:0]              perf_busy_cycles_o,
   output logic [31:0]              perf_stall_cycles_o
);

   localparam int PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int NW = $clog2(FifoDepth + 1);
   localparam int RW = $clog2(FifoDepth + DecoderUnits + 1);
   localparam logic [RW-1:0] M_RES  = RW'(DecoderUnits);
   localparam logic [RW-1:0] FD_RES = RW'(FifoDepth);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      ptr_next = (p == PW'(FifoDepth - 1)) ? {PW{1'b0}} : p + PW'(1);
   endfunction

   state_e                   state_r, state_s;
   logic                     done_r, done_s, err_r;
   logic [15:0]              num_rows_r, row_cnt_r;
   logic [31:0]              total_r, rcv_cnt_r;
   logic [CA-1:0]            c_cnt_r;
   logic [RW-1:0]            reserved_r;
   logic [DA-1:0]            exp_m_r;
   logic                     dec_we_r;
   logic [DA-1:0]            dec_m_addr_r;
   logic [TA-1:0]            dec_waddr_r;
   logic [DataTypeWidth-1:0] dec_wdata_r;
   logic [CA-1:0]            dec_c_addr_r;
   logic [TD-1:0]            dec_k_addr_r;
   logic [32+DA-1:0]         mem_r [FifoDepth];
   logic [PW-1:0]            wr_ptr_r, rd_ptr_r;
   logic [NW-1:0]            count_r;

   logic start_acc_s, lut_acc_s, enc_acc_s, c_wrap_s, last_row_s;
   logic pop_s, full_s, push_s, drop_s, mism_s, res_add_s, res_sub_s;

   assign start_acc_s = start_i && (state_r == IDLE);
   assign lut_acc_s   = lut_valid_i && lut_ready_o;
   assign enc_acc_s   = enc_valid_i && enc_ready_o;
   assign c_wrap_s    = (c_cnt_r == CA'(C - 1));
   assign last_row_s  = (row_cnt_r == (num_rows_r - 16'd1));
   assign full_s      = (count_r == NW'(FifoDepth));
   assign pop_s       = res_valid_o && res_ready_i;
   assign push_s      = dec_valid_i && (!full_s || pop_s);
   assign drop_s      = dec_valid_i && full_s && !pop_s;
   assign mism_s      = dec_valid_i && (dec_m_addr_i != exp_m_r);
   assign res_add_s   = enc_acc_s && (c_cnt_r == CA'(0));
   assign res_sub_s   = pop_s && (reserved_r != RW'(0));

   assign busy_o        = (state_r != IDLE);
   assign dec_decoder_o = (state_r != IDLE);
   assign lut_ready_o   = (state_r == IDLE);
   // A new row may only start once the FIFO has room for all of its results.
   assign enc_ready_o   = (state_r == RUN) && ((c_cnt_r != CA'(0)) || ((reserved_r + M_RES) <= FD_RES));
   assign done_o        = done_r;
   assign err_o         = err_r;
   assign dec_we_o      = dec_we_r;
   assign dec_m_addr_o  = dec_m_addr_r;
   assign dec_waddr_o   = dec_waddr_r;
   assign dec_wdata_o   = dec_wdata_r;
   assign dec_c_addr_o  = dec_c_addr_r;
   assign dec_k_addr_o  = dec_k_addr_r;
   assign res_valid_o   = (count_r != NW'(0));
   assign res_data_o    = mem_r[rd_ptr_r][32+DA-1:DA];
   assign res_m_o       = mem_r[rd_ptr_r][DA-1:0];

   // Next-state and done decode.
   always_comb begin
      state_s = state_r;
      done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_i && (num_rows_i != 16'd0)) state_s = RUN;
            else if (start_i) done_s = 1'b1;
            else state_s = IDLE;
         end
         RUN: begin
            if (enc_acc_s && c_wrap_s && last_row_s) state_s = DRAIN;
            else state_s = RUN;
         end
         DRAIN: begin
            if (rcv_cnt_r == total_r) begin
               state_s = IDLE;
               done_s  = 1'b1;
            end else begin
               state_s = DRAIN;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State, done pulse and sticky error.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= IDLE;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         done_r  <= done_s;
         if (drop_s || mism_s) err_r <= 1'b1;
         else if (start_acc_s) err_r <= 1'b0;
         else err_r <= err_r;
      end
   end

   // Run bookkeeping: row/codebook counters, latched length, result count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         num_rows_r <= 16'd0;
         total_r    <= 32'd0;
         row_cnt_r  <= 16'd0;
         c_cnt_r    <= CA'(0);
         rcv_cnt_r  <= 32'd0;
      end else if (start_acc_s) begin
         num_rows_r <= num_rows_i;
         total_r    <= 32'(num_rows_i) * 32'(DecoderUnits);
         row_cnt_r  <= 16'd0;
         c_cnt_r    <= CA'(0);
         rcv_cnt_r  <= 32'd0;
      end else begin
         if (enc_acc_s && c_wrap_s) begin
            c_cnt_r   <= CA'(0);
            row_cnt_r <= row_cnt_r + 16'd1;
         end else if (enc_acc_s) begin
            c_cnt_r <= c_cnt_r + CA'(1);
         end
         if (dec_valid_i && (state_r != IDLE)) rcv_cnt_r <= rcv_cnt_r + 32'd1;
      end
   end

   // Decoder-array drive registers for LUT writes and index lookups.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dec_we_r     <= 1'b0;
         dec_m_addr_r <= DA'(0);
         dec_waddr_r  <= TA'(0);
         dec_wdata_r  <= DataTypeWidth'(0);
         dec_c_addr_r <= CA'(0);
         dec_k_addr_r <= TD'(0);
      end else begin
         dec_we_r <= lut_acc_s;
         if (lut_acc_s) begin
            dec_m_addr_r <= lut_m_i;
            dec_waddr_r  <= lut_addr_i;
            dec_wdata_r  <= lut_data_i;
         end
         if (enc_acc_s) begin
            dec_c_addr_r <= c_cnt_r;
            dec_k_addr_r <= enc_k_i;
         end
      end
   end

   // Credit reservation and expected decoder-index tracker.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         reserved_r <= RW'(0);
         exp_m_r    <= DA'(0);
      end else begin
         case ({res_add_s, res_sub_s})
            2'b10:   reserved_r <= reserved_r + M_RES;
            2'b01:   reserved_r <= reserved_r - RW'(1);
            2'b11:   reserved_r <= reserved_r + M_RES - RW'(1);
            default: reserved_r <= reserved_r;
         endcase
         if (start_acc_s) exp_m_r <= DA'(0);
         else if (dec_valid_i)
            exp_m_r <= (exp_m_r == DA'(DecoderUnits - 1)) ? DA'(0) : exp_m_r + DA'(1);
      end
   end

   // Result FIFO pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= NW'(0);
      end else begin
         if (push_s) wr_ptr_r <= ptr_next(wr_ptr_r);
         if (pop_s)  rd_ptr_r <= ptr_next(rd_ptr_r);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + NW'(1);
            2'b01:   count_r <= count_r - NW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Result FIFO storage.
   always_ff @(posedge clk_i) begin
      if (push_s) mem_r[wr_ptr_r] <= {dec_result_i, dec_m_addr_i};
   end

`ifdef HALUT_CTRL_PERF_EN
   logic [31:0] perf_busy_r, perf_stall_r;

   // Saturating busy and stall cycle counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_busy_r  <= 32'd0;
         perf_stall_r <= 32'd0;
      end else if (start_acc_s) begin
         perf_busy_r  <= 32'd0;
         perf_stall_r <= 32'd0;
      end else begin
         if (busy_o && (perf_busy_r != 32'hFFFF_FFFF)) perf_busy_r <= perf_busy_r + 32'd1;
         if ((state_r == RUN) && enc_valid_i && !enc_ready_o && (perf_stall_r != 32'hFFFF_FFFF))
            perf_stall_r <= perf_stall_r + 32'd1;
      end
   end

   assign perf_busy_cycles_o  = perf_busy_r;
   assign perf_stall_cycles_o = perf_stall_r;
`else
   assign perf_busy_cycles_o  = 32'd0;
   assign perf_stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_halut_decoder_ctrl.sv
// Directed bench for halut_decoder_ctrl with a behavioural decoder-array model (M=4, C=3, FIFO 8).
module tb_halut_decoder_ctrl;
   localparam int M = 4, C = 3, DA = 2, CA = 2, TD = 4, TA = 6, DW = 8;

   logic clk_i = 1'b0;
   logic rst_ni, start_i, lut_valid_i, enc_valid_i, dec_valid_i, res_ready_i;
   logic [15:0] num_rows_i;
   logic busy_o, done_o, err_o, lut_ready_o, enc_ready_o, dec_we_o, dec_decoder_o, res_valid_o;
   logic [DA-1:0] lut_m_i, dec_m_addr_o, dec_m_addr_i, res_m_o;
   logic [TA-1:0] lut_addr_i, dec_waddr_o;
   logic [DW-1:0] lut_data_i, dec_wdata_o;
   logic [TD-1:0] enc_k_i, dec_k_addr_o;
   logic [CA-1:0] dec_c_addr_o;
   logic [31:0] dec_result_i, res_data_o, perf_busy_cycles_o, perf_stall_cycles_o;

   halut_decoder_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .num_rows_i(num_rows_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .lut_valid_i(lut_valid_i), .lut_ready_o(lut_ready_o), .lut_m_i(lut_m_i),
      .lut_addr_i(lut_addr_i), .lut_data_i(lut_data_i),
      .enc_valid_i(enc_valid_i), .enc_ready_o(enc_ready_o), .enc_k_i(enc_k_i),
      .dec_m_addr_o(dec_m_addr_o), .dec_waddr_o(dec_waddr_o), .dec_wdata_o(dec_wdata_o),
      .dec_we_o(dec_we_o), .dec_c_addr_o(dec_c_addr_o), .dec_k_addr_o(dec_k_addr_o),
      .dec_decoder_o(dec_decoder_o), .dec_result_i(dec_result_i), .dec_valid_i(dec_valid_i),
      .dec_m_addr_i(dec_m_addr_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_data_o(res_data_o), .res_m_o(res_m_o),
      .perf_busy_cycles_o(perf_busy_cycles_o), .perf_stall_cycles_o(perf_stall_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0, errors = 0;
   int beats = 0, mc = 0, mrow = 0, mres = 0, done_cnt = 0;
   int corrupt_at = -1;
   logic acc_q = 1'b0;
   logic [31:0] pend_q[$];
   int c_log[$], k_log[$];
   logic [31:0] out_d_q[$];
   int out_m_q[$];

   // Decoder-array model and output monitor, evaluated mid-cycle where everything is stable.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         pend_q.delete();
         mc = 0;
         acc_q = 1'b0;
         dec_valid_i = 1'b0;
      end else begin
         if (acc_q) begin
            c_log.push_back(int'(dec_c_addr_o));
            k_log.push_back(int'(dec_k_addr_o));
            beats++;
            enc_k_i = TD'(beats);
         end
         if (pend_q.size() > 0) begin
            dec_result_i = pend_q.pop_front();
            dec_valid_i  = 1'b1;
            dec_m_addr_i = (mres == corrupt_at) ? 2'd3 : dec_result_i[DA-1:0];
            mres++;
         end else begin
            dec_valid_i = 1'b0;
         end
         if (res_valid_o && res_ready_i) begin
            out_d_q.push_back(res_data_o);
            out_m_q.push_back(int'(res_m_o));
         end
         if (done_o) done_cnt++;
         acc_q = enc_valid_i && enc_ready_o;
         if (acc_q && (mc == C - 1)) begin
            mc = 0;
            for (int m = 0; m < M; m++) pend_q.push_back(32'((mrow << 8) | m));
            mrow++;
         end else if (acc_q) begin
            mc++;
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) tick();
      chk(tag, 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin
      int ob, cb, bb, dc;
      rst_ni = 1'b0; start_i = 1'b0; num_rows_i = 16'd0; lut_valid_i = 1'b0;
      lut_m_i = 2'd0; lut_addr_i = 6'd0; lut_data_i = 8'd0; enc_valid_i = 1'b0;
      enc_k_i = 4'd0; dec_valid_i = 1'b0; dec_result_i = 32'd0; dec_m_addr_i = 2'd0;
      res_ready_i = 1'b1;
      tick(); tick();
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_we", 32'(dec_we_o), 32'd0);
      chk("rst_decoder", 32'(dec_decoder_o), 32'd0);
      chk("rst_res_valid", 32'(res_valid_o), 32'd0);
      chk("rst_lut_ready", 32'(lut_ready_o), 32'd1);
      rst_ni = 1'b1;
      tick();

      // LUT load in IDLE
      lut_valid_i = 1'b1; lut_m_i = 2'd2; lut_addr_i = 6'd5; lut_data_i = 8'h3C;
      tick();
      lut_valid_i = 1'b0;
      chk("lut_we", 32'(dec_we_o), 32'd1);
      chk("lut_m", 32'(dec_m_addr_o), 32'd2);
      chk("lut_addr", 32'(dec_waddr_o), 32'd5);
      chk("lut_data", 32'(dec_wdata_o), 32'h3C);
      tick();
      chk("lut_we_off", 32'(dec_we_o), 32'd0);

      // Two-row run, free-flowing output
      num_rows_i = 16'd2; start_i = 1'b1; enc_valid_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("run_busy", 32'(busy_o), 32'd1);
      chk("run_decoder", 32'(dec_decoder_o), 32'd1);
      chk("run_lut_ready", 32'(lut_ready_o), 32'd0);
      wait_done("run1_done", 100);
      enc_valid_i = 1'b0;
      tick(); tick(); tick();
      chk("run1_single_done", 32'(done_cnt), 32'd1);
      chk("run1_idle", 32'(busy_o), 32'd0);
      chk("run1_decoder_off", 32'(dec_decoder_o), 32'd0);
      chk("run1_beats", 32'(c_log.size()), 32'd6);
      for (int i = 0; i < 6 && i < c_log.size(); i++) begin
         chk("run1_c_addr", 32'(c_log[i]), 32'(i % C));
         chk("run1_k_addr", 32'(k_log[i]), 32'(i));
      end
      chk("run1_results", 32'(out_d_q.size()), 32'd8);
      for (int i = 0; i < 8 && i < out_d_q.size(); i++) begin
         chk("run1_res_m", 32'(out_m_q[i]), 32'(i % M));
         chk("run1_res_data", out_d_q[i], 32'(((i / M) << 8) | (i % M)));
      end
      chk("run1_err", 32'(err_o), 32'd0);
`ifndef HALUT_CTRL_PERF_EN
      chk("perf_busy_zero", perf_busy_cycles_o, 32'd0);
      chk("perf_stall_zero", perf_stall_cycles_o, 32'd0);
`endif

      // Three rows with output blocked: third row must wait for credit
      ob = out_d_q.size(); cb = c_log.size();
      res_ready_i = 1'b0; num_rows_i = 16'd3; start_i = 1'b1; enc_valid_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      chk("stall_ready", 32'(enc_ready_o), 32'd0);
      chk("stall_busy", 32'(busy_o), 32'd1);
      chk("stall_beats", 32'(c_log.size() - cb), 32'd6);
      chk("stall_c_addr", 32'(dec_c_addr_o), 32'd2);
      chk("stall_res_valid", 32'(res_valid_o), 32'd1);
      chk("stall_no_pop", 32'(out_d_q.size() - ob), 32'd0);
      chk("stall_err", 32'(err_o), 32'd0);
      res_ready_i = 1'b1;
      wait_done("run2_done", 100);
      enc_valid_i = 1'b0;
      tick(); tick();
      chk("run2_results", 32'(out_d_q.size() - ob), 32'd12);
      for (int i = 0; i < 12 && ob + i < out_d_q.size(); i++) begin
         chk("run2_res_m", 32'(out_m_q[ob + i]), 32'(i % M));
         chk("run2_res_data", out_d_q[ob + i], 32'(((2 + i / M) << 8) | (i % M)));
      end
      chk("run2_err", 32'(err_o), 32'd0);

      // Decoder index mismatch: second result of the row reports m=3
      corrupt_at = mres + 1;
      num_rows_i = 16'd1; start_i = 1'b1; enc_valid_i = 1'b1;
      tick();
      start_i = 1'b0;
      wait_done("run3_done", 100);
      enc_valid_i = 1'b0;
      chk("mism_err", 32'(err_o), 32'd1);
      tick(); tick(); tick();
      chk("mism_err_sticky", 32'(err_o), 32'd1);
      num_rows_i = 16'd0; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("start_clears_err", 32'(err_o), 32'd0);
      chk("zero_rows_done", 32'(done_o), 32'd1);
      chk("zero_rows_busy", 32'(busy_o), 32'd0);
      tick();

      // Reset in the middle of a run
      num_rows_i = 16'd2; start_i = 1'b1; enc_valid_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick(); tick(); tick();
      chk("mid_busy", 32'(busy_o), 32'd1);
      bb = done_cnt;
      rst_ni = 1'b0;
      #1;
      chk("mrst_busy", 32'(busy_o), 32'd0);
      chk("mrst_decoder", 32'(dec_decoder_o), 32'd0);
      chk("mrst_we", 32'(dec_we_o), 32'd0);
      chk("mrst_c_addr", 32'(dec_c_addr_o), 32'd0);
      chk("mrst_k_addr", 32'(dec_k_addr_o), 32'd0);
      chk("mrst_res_valid", 32'(res_valid_o), 32'd0);
      chk("mrst_done", 32'(done_o), 32'd0);
      chk("mrst_enc_ready", 32'(enc_ready_o), 32'd0);
      enc_valid_i = 1'b0;
      tick(); tick();
      rst_ni = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("post_rst_fifo_empty", 32'(res_valid_o), 32'd0);
      chk("post_rst_busy", 32'(busy_o), 32'd0);
      chk("post_rst_no_done", 32'(done_cnt - bb), 32'd0);
      num_rows_i = 16'd0; start_i = 1'b1;
      dc = done_cnt;
      tick();
      start_i = 1'b0;
      chk("zero2_done", 32'(done_o), 32'd1);
      chk("zero2_busy", 32'(busy_o), 32'd0);
      tick();
      chk("zero2_done_pulse", 32'(done_o), 32'd0);
      chk("zero2_busy_after", 32'(busy_o), 32'd0);
      chk("zero2_one_pulse", 32'(done_cnt - dc), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
